// File: rtl/demux_serial_framer_if.sv
// Bundles the serial input and demux-side outputs of the framer.
interface demux_serial_framer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sin;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             frame_done;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;

  // Source side: drives the bitstream, observes status.
  modport master (
    output sin, in_valid,
    input  a, b, c, d, busy, frame_done, frame_err, frame_cnt
  );

  // Framer side.
  modport slave (
    input  sin, in_valid,
    output a, b, c, d, busy, frame_done, frame_err, frame_cnt
  );
endinterface

// File: rtl/demux_serial_framer.sv
// Serial framer feeding a 1:8 demux: start bit, 3-bit address (MSB first),
// DATA_BITS payload bits, stop bit. Steers payload onto d with selects a,b,c.
module demux_serial_framer #(
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned CNT_W     = 8
) (
  input logic                  clk,
  input logic                  rst,
  demux_serial_framer_if.slave bus
);

  // Counter must hold 0..2 for the address and 0..DATA_BITS-1 for payload.
  localparam int unsigned CntW = ($clog2(DATA_BITS) > 2) ? $clog2(DATA_BITS) : 2;
  localparam logic [CntW-1:0] LastAddr = CntW'(2);
  localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]       addr_q, addr_d;
  logic [2:0]       sel_q, sel_d;
  logic             d_q, d_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  // State, counters and registered outputs; async reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      sel_q     <= '0;
      d_q       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      d_q       <= d_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // Next-state logic; nothing advances without in_valid, pulses drop back to 0.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    d_d       = d_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fcnt_d    = fcnt_q;
    if (bus.in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.sin) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
          end
        end
        StAddr: begin
          if (bit_cnt_q == LastAddr) begin
            // All three select bits change together on the last address bit.
            sel_d     = {addr_q, bus.sin};
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            addr_d    = {addr_q[0], bus.sin};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StData: begin
          d_d = bus.sin;
          if (bit_cnt_q == LastData) begin
            state_d   = StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StStop: begin
          d_d     = 1'b0;
          state_d = StIdle;
          if (!bus.sin) begin
            done_d = 1'b1;
            if (fcnt_q != {CNT_W{1'b1}}) fcnt_d = fcnt_q + 1'b1;
          end else begin
            // Bad stop bit is consumed here, never reinterpreted as a start.
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.a          = sel_q[2];
  assign bus.b          = sel_q[1];
  assign bus.c          = sel_q[0];
  assign bus.d          = d_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.frame_cnt  = fcnt_q;

endmodule
